// File: rtl/control_pkg.sv
// control_pkg: shared types and codes for the control sequencer.
//   state_e      : sequencer states
//   alu_op_e     : ALU operation codes
//   A/B selects  : ALU operand source codes
//   rd_sel_e     : register writeback source
//   pc_sel_e     : next-PC source (STALL holds the PC, TRAP vectors to handler)
//   mem_acc_e    : memory access size
//   trap_cause_e : trap cause codes
//   dec_t        : decoded instruction bundle from control_decode
package control_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_MULDIV   = 3'd3,
    ST_TRAP     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [1:0] {
    RD_ALU    = 2'd0,
    RD_MEM    = 2'd1,
    RD_PC4    = 2'd2,
    RD_MULDIV = 2'd3
  } rd_sel_e;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_STALL  = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_JALR   = 3'd4,
    PC_TRAP   = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } mem_acc_e;

  typedef enum logic [1:0] {
    TC_ILLEGAL     = 2'd0,
    TC_MEM_TIMEOUT = 2'd1,
    TC_MISALIGNED  = 2'd2
  } trap_cause_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic        reg_wr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        a_sel;
    logic        b_sel;
    rd_sel_e     rd_sel;
    pc_sel_e     pc_sel;
    logic [31:0] pc_off;
    logic        mem_wr;
    logic        mem_sext;
    mem_acc_e    mem_acc;
    logic        is_mem;
    logic        is_muldiv;
    logic        illegal;
  } dec_t;

  // funct3 -> ALU op; alt selects SUB/SRA over ADD/SRL
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    if (alt) op = ALU_SUB; else op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    if (alt) op = ALU_SRA; else op = ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_misaligned(input mem_acc_e acc, input logic [1:0] addr_lo);
    return ((acc == ACC_HALF) && addr_lo[0]) ||
           ((acc == ACC_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: pure combinational RV32I (+ optional M) instruction decoder.
//   instr_i : 32-bit instruction word
//   dec_o   : datapath controls plus class flags is_mem / is_muldiv / illegal
// Build option: CONTROL_SEQ_MULDIV_EN enables decoding of funct7=0000001 OP
// instructions as mul/div; otherwise they decode as illegal.
// Illegal instructions never carry a write enable or class flag.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o.reg_wr    = 1'b0;
    dec_o.rd        = instr_i[11:7];
    dec_o.rs1       = instr_i[19:15];
    dec_o.rs2       = instr_i[24:20];
    dec_o.imm       = '0;
    dec_o.alu_op    = ALU_ADD;
    dec_o.a_sel     = A_SEL_RS1;
    dec_o.b_sel     = B_SEL_RS2;
    dec_o.rd_sel    = RD_ALU;
    dec_o.pc_sel    = PC_NEXT;
    dec_o.pc_off    = '0;
    dec_o.mem_wr    = 1'b0;
    dec_o.mem_sext  = 1'b0;
    dec_o.mem_acc   = ACC_BYTE;
    dec_o.is_mem    = 1'b0;
    dec_o.is_muldiv = 1'b0;
    dec_o.illegal   = 1'b0;

    case (opc)
      OPC_LUI: begin
        dec_o.reg_wr = 1'b1;
        dec_o.imm    = imm_u;
        dec_o.b_sel  = B_SEL_IMM;
        dec_o.alu_op = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_o.reg_wr = 1'b1;
        dec_o.imm    = imm_u;
        dec_o.a_sel  = A_SEL_PC;
        dec_o.b_sel  = B_SEL_IMM;
      end
      OPC_JAL: begin
        dec_o.reg_wr = 1'b1;
        dec_o.imm    = imm_j;
        dec_o.pc_off = imm_j;
        dec_o.rd_sel = RD_PC4;
        dec_o.pc_sel = PC_JAL;
      end
      OPC_JALR: begin
        // target comes from the ALU (rs1 + imm)
        dec_o.reg_wr  = 1'b1;
        dec_o.imm     = imm_i;
        dec_o.b_sel   = B_SEL_IMM;
        dec_o.rd_sel  = RD_PC4;
        dec_o.pc_sel  = PC_JALR;
        dec_o.illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        // ALU does the compare; datapath applies funct3[0] polarity
        dec_o.imm    = imm_b;
        dec_o.pc_off = imm_b;
        dec_o.pc_sel = PC_BRANCH;
        case (f3[2:1])
          2'b00:   dec_o.alu_op  = ALU_SUB;
          2'b10:   dec_o.alu_op  = ALU_SLT;
          2'b11:   dec_o.alu_op  = ALU_SLTU;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_o.reg_wr   = 1'b1;
        dec_o.imm      = imm_i;
        dec_o.b_sel    = B_SEL_IMM;
        dec_o.rd_sel   = RD_MEM;
        dec_o.is_mem   = 1'b1;
        dec_o.mem_sext = ~f3[2];
        dec_o.mem_acc  = mem_acc_e'(f3[1:0]);
        dec_o.illegal  = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
      end
      OPC_STORE: begin
        dec_o.imm     = imm_s;
        dec_o.b_sel   = B_SEL_IMM;
        dec_o.is_mem  = 1'b1;
        dec_o.mem_wr  = 1'b1;
        dec_o.mem_acc = mem_acc_e'(f3[1:0]);
        dec_o.illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        dec_o.reg_wr  = 1'b1;
        dec_o.imm     = imm_i;
        dec_o.b_sel   = B_SEL_IMM;
        dec_o.alu_op  = alu_op_from_f3(f3, (f3 == 3'd5) && (f7 == F7_ALT));
        dec_o.illegal = ((f3 == 3'd1) && (f7 != F7_BASE)) ||
                        ((f3 == 3'd5) && (f7 != F7_BASE) && (f7 != F7_ALT));
      end
      OPC_OP: begin
        dec_o.reg_wr = 1'b1;
        case (f7)
          F7_BASE: dec_o.alu_op = alu_op_from_f3(f3, 1'b0);
          F7_ALT: begin
            if ((f3 == 3'd0) || (f3 == 3'd5)) dec_o.alu_op  = alu_op_from_f3(f3, 1'b1);
            else                              dec_o.illegal = 1'b1;
          end
          F7_MULDIV: begin
`ifdef CONTROL_SEQ_MULDIV_EN
            dec_o.is_muldiv = 1'b1;
            dec_o.rd_sel    = RD_MULDIV;
`else
            dec_o.illegal   = 1'b1;
`endif
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      default: dec_o.illegal = 1'b1;
    endcase

    if (dec_o.illegal) begin
      dec_o.reg_wr    = 1'b0;
      dec_o.mem_wr    = 1'b0;
      dec_o.is_mem    = 1'b0;
      dec_o.is_muldiv = 1'b0;
    end
  end

endmodule

// File: rtl/control_seq.sv
// control_seq: multi-cycle control sequencer (FSM, counters, output gating).
// Parameters : MEM_TIMEOUT (1..255) wait cycles before a memory timeout trap,
//              MULDIV_CYCLES (1..64) fixed mul/div unit latency.
// Inputs     : clk_i, rst_i (async, active-high), instr_i, instr_valid_i,
//              mem_ack_i, alu_result_i (load/store address).
// Outputs    : datapath controls (reg_wr_en_o, rd/rs1/rs2_idx_o, imm_data_o,
//              alu_op_o, alu_a/b_sel_o, rd_sel_o, pc_next_off_o, pc_next_sel_o),
//              memory controls (mem_req_o, mem_wr_en_o, mem_r_sext_o, mem_acc_o),
//              muldiv_start_o, busy_o, trap_o, trap_cause_o.
// Build option: CONTROL_SEQ_MULDIV_EN adds the MULDIV state and its counter.
module control_seq
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        mem_ack_i,
  input  logic [31:0] alu_result_i,
  output logic        reg_wr_en_o,
  output logic [4:0]  rd_idx_o,
  output logic [4:0]  rs1_idx_o,
  output logic [4:0]  rs2_idx_o,
  output logic [31:0] imm_data_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic [1:0]  rd_sel_o,
  output logic [31:0] pc_next_off_o,
  output logic [2:0]  pc_next_sel_o,
  output logic        mem_req_o,
  output logic        mem_wr_en_o,
  output logic        mem_r_sext_o,
  output logic [1:0]  mem_acc_o,
  output logic        muldiv_start_o,
  output logic        busy_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  dec_t        dec;
  logic [7:0]  tmo_cnt_q;
  logic        tmo_hit;
  logic        misalign;
  logic        fields_on;
  logic        unused_addr;

  control_decode u_dec (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  assign misalign    = is_misaligned(dec.mem_acc, alu_result_i[1:0]);
  assign unused_addr = ^alu_result_i[31:2];
  // last permitted wait cycle; an ack here still completes the access
  assign tmo_hit     = (tmo_cnt_q == 8'(MEM_TIMEOUT - 1));
  assign busy_o      = (state_q == ST_MEM_WAIT) || (state_q == ST_MULDIV);
  assign fields_on   = ((state_q == ST_EXEC) && instr_valid_i) || busy_o;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      cause_q <= TC_ILLEGAL;
    end else begin
      state_q <= state_d;
      if (state_d == ST_TRAP) cause_q <= cause_d;
    end
  end

  // wait counter is held at zero outside MEM_WAIT, so it is clear on entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       tmo_cnt_q <= '0;
    else if (state_q != ST_MEM_WAIT) tmo_cnt_q <= '0;
    else                             tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end

`ifdef CONTROL_SEQ_MULDIV_EN
  logic [6:0] md_cnt_q;
  logic       md_last;

  assign md_last = (md_cnt_q == 7'(MULDIV_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     md_cnt_q <= '0;
    else if (state_q != ST_MULDIV) md_cnt_q <= '0;
    else                           md_cnt_q <= md_cnt_q + 7'd1;
  end
`else
  localparam int unused_md_cycles = MULDIV_CYCLES;
  assign muldiv_start_o = 1'b0;
`endif

  // next-state
  always_comb begin
    state_d = state_q;
    cause_d = TC_ILLEGAL;
    case (state_q)
      ST_RESET: state_d = ST_EXEC;
      ST_EXEC: begin
        if (instr_valid_i) begin
          if (dec.illegal) begin
            state_d = ST_TRAP;
            cause_d = TC_ILLEGAL;
          end else if (dec.is_mem && misalign) begin
            state_d = ST_TRAP;
            cause_d = TC_MISALIGNED;
          end else if (dec.is_mem) begin
            state_d = ST_MEM_WAIT;
          end else if (dec.is_muldiv) begin
`ifdef CONTROL_SEQ_MULDIV_EN
            state_d = ST_MULDIV;
`endif
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_EXEC;
        end else if (tmo_hit) begin
          state_d = ST_TRAP;
          cause_d = TC_MEM_TIMEOUT;
        end
      end
`ifdef CONTROL_SEQ_MULDIV_EN
      ST_MULDIV: if (md_last) state_d = ST_EXEC;
`endif
      ST_TRAP: state_d = ST_EXEC;
      default: state_d = ST_RESET;
    endcase
  end

  // outputs; RESET (and thus rst_i) leaves everything at zero except STALL
  always_comb begin
    reg_wr_en_o   = 1'b0;
    rd_idx_o      = '0;
    rs1_idx_o     = '0;
    rs2_idx_o     = '0;
    imm_data_o    = '0;
    alu_op_o      = '0;
    alu_a_sel_o   = 1'b0;
    alu_b_sel_o   = 1'b0;
    rd_sel_o      = '0;
    pc_next_off_o = '0;
    pc_next_sel_o = PC_STALL;
    mem_req_o     = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_r_sext_o  = 1'b0;
    mem_acc_o     = '0;
    trap_o        = 1'b0;
    trap_cause_o  = '0;
`ifdef CONTROL_SEQ_MULDIV_EN
    muldiv_start_o = 1'b0;
`endif

    if (fields_on) begin
      rd_idx_o      = dec.rd;
      rs1_idx_o     = dec.rs1;
      rs2_idx_o     = dec.rs2;
      imm_data_o    = dec.imm;
      alu_op_o      = dec.alu_op;
      alu_a_sel_o   = dec.a_sel;
      alu_b_sel_o   = dec.b_sel;
      rd_sel_o      = dec.rd_sel;
      pc_next_off_o = dec.pc_off;
      mem_r_sext_o  = dec.mem_sext;
      mem_acc_o     = dec.mem_acc;
    end

    case (state_q)
      ST_EXEC: begin
        if (instr_valid_i && !dec.illegal) begin
          if (dec.is_mem) begin
            if (!misalign) begin
              mem_req_o   = 1'b1;
              mem_wr_en_o = dec.mem_wr;
            end
          end else if (dec.is_muldiv) begin
`ifdef CONTROL_SEQ_MULDIV_EN
            muldiv_start_o = 1'b1;
`endif
          end else begin
            reg_wr_en_o   = dec.reg_wr;
            pc_next_sel_o = dec.pc_sel;
          end
        end
      end
      ST_MEM_WAIT: begin
        mem_req_o   = 1'b1;
        mem_wr_en_o = dec.mem_wr;
        if (mem_ack_i) begin
          reg_wr_en_o   = ~dec.mem_wr;
          pc_next_sel_o = PC_NEXT;
        end
      end
`ifdef CONTROL_SEQ_MULDIV_EN
      ST_MULDIV: begin
        if (md_last) begin
          reg_wr_en_o   = 1'b1;
          rd_sel_o      = RD_MULDIV;
          pc_next_sel_o = PC_NEXT;
        end
      end
`endif
      ST_TRAP: begin
        trap_o        = 1'b1;
        trap_cause_o  = cause_q;
        pc_next_sel_o = PC_TRAP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq; covers the mul/div path in both builds.
module tb_control_seq;

  localparam int P_NEXT = 0, P_STALL = 1, P_BRANCH = 2, P_JAL = 3, P_TRAP = 5;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A103;
  localparam logic [31:0] I_LH   = 32'h0000_9103;
  localparam logic [31:0] I_SW   = 32'h0020_A223;
  localparam logic [31:0] I_MUL  = 32'h0220_81B3;
  localparam logic [31:0] I_JAL  = 32'h0080_00EF;
  localparam logic [31:0] I_BEQ  = 32'h0000_0863;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = I_ADDI;
  logic        instr_valid_i = 1'b1;
  logic        mem_ack_i = 1'b1;
  logic [31:0] alu_result_i = '0;

  logic        reg_wr_en_o;
  logic [4:0]  rd_idx_o, rs1_idx_o, rs2_idx_o;
  logic [31:0] imm_data_o, pc_next_off_o;
  logic [3:0]  alu_op_o;
  logic        alu_a_sel_o, alu_b_sel_o;
  logic [1:0]  rd_sel_o;
  logic [2:0]  pc_next_sel_o;
  logic        mem_req_o, mem_wr_en_o, mem_r_sext_o;
  logic [1:0]  mem_acc_o;
  logic        muldiv_start_o, busy_o, trap_o;
  logic [1:0]  trap_cause_o;
  logic        any_nz;

  int checks = 0;
  int errors = 0;

  control_seq #(.MEM_TIMEOUT(16), .MULDIV_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .mem_ack_i(mem_ack_i), .alu_result_i(alu_result_i),
    .reg_wr_en_o(reg_wr_en_o), .rd_idx_o(rd_idx_o), .rs1_idx_o(rs1_idx_o),
    .rs2_idx_o(rs2_idx_o), .imm_data_o(imm_data_o), .alu_op_o(alu_op_o),
    .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .rd_sel_o(rd_sel_o),
    .pc_next_off_o(pc_next_off_o), .pc_next_sel_o(pc_next_sel_o),
    .mem_req_o(mem_req_o), .mem_wr_en_o(mem_wr_en_o), .mem_r_sext_o(mem_r_sext_o),
    .mem_acc_o(mem_acc_o), .muldiv_start_o(muldiv_start_o), .busy_o(busy_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  // every output other than pc_next_sel_o, OR-reduced
  assign any_nz = |{reg_wr_en_o, rd_idx_o, rs1_idx_o, rs2_idx_o, imm_data_o, alu_op_o,
                    alu_a_sel_o, alu_b_sel_o, rd_sel_o, pc_next_off_o, mem_req_o,
                    mem_wr_en_o, mem_r_sext_o, mem_acc_o, muldiv_start_o, busy_o,
                    trap_o, trap_cause_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with a valid ADDI and ack driven: everything gated off
    #2;
    chk("rst_pc", 32'(pc_next_sel_o), 32'(P_STALL));
    chk("rst_outputs_zero", 32'(any_nz), 32'd0);

    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0; instr_valid_i = 1'b0; mem_ack_i = 1'b0; #1;
    chk("reset_state_stall", 32'(pc_next_sel_o), 32'(P_STALL));

    @(negedge clk_i); #1;
    chk("idle_stall", 32'(pc_next_sel_o), 32'(P_STALL));
    chk("idle_no_write", 32'({reg_wr_en_o, mem_req_o, busy_o}), 32'd0);

    // ADDI x1,x0,5
    @(negedge clk_i); instr_i = I_ADDI; instr_valid_i = 1'b1; #1;
    chk("addi_wr", 32'(reg_wr_en_o), 32'd1);
    chk("addi_imm", imm_data_o, 32'd5);
    chk("addi_rd", 32'(rd_idx_o), 32'd1);
    chk("addi_bsel", 32'(alu_b_sel_o), 32'd1);
    chk("addi_pc", 32'(pc_next_sel_o), 32'(P_NEXT));

    // JAL x1,+8 and BEQ x0,x0,+16
    @(negedge clk_i); instr_i = I_JAL; #1;
    chk("jal_pc", 32'(pc_next_sel_o), 32'(P_JAL));
    chk("jal_off", pc_next_off_o, 32'd8);
    chk("jal_wr", 32'(reg_wr_en_o), 32'd1);
    @(negedge clk_i); instr_i = I_BEQ; #1;
    chk("beq_pc", 32'(pc_next_sel_o), 32'(P_BRANCH));
    chk("beq_off", pc_next_off_o, 32'd16);
    chk("beq_no_wr", 32'(reg_wr_en_o), 32'd0);

    // LW at 0x100, ack on the third wait cycle
    @(negedge clk_i); instr_i = I_LW; alu_result_i = 32'h100; #1;
    chk("lw_exec_req", 32'(mem_req_o), 32'd1);
    chk("lw_exec_stall", 32'(pc_next_sel_o), 32'(P_STALL));
    chk("lw_exec_no_wr", 32'(reg_wr_en_o), 32'd0);
    chk("lw_acc_sext", 32'({mem_acc_o, mem_r_sext_o, mem_wr_en_o}), 32'b1010);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i); mem_ack_i = (k == 3); #1;
      chk("lw_wait_req", 32'({mem_req_o, busy_o}), 32'b11);
      chk("lw_wait_wr", 32'(reg_wr_en_o), 32'(k == 3));
      chk("lw_wait_pc", 32'(pc_next_sel_o), (k == 3) ? 32'(P_NEXT) : 32'(P_STALL));
    end
    @(negedge clk_i); mem_ack_i = 1'b0; instr_valid_i = 1'b0; #1;
    chk("lw_done", 32'({mem_req_o, busy_o, reg_wr_en_o}), 32'd0);

    // ack while idle in EXEC is ignored
    @(negedge clk_i); mem_ack_i = 1'b1; #1;
    chk("stray_ack", 32'({reg_wr_en_o, mem_req_o, busy_o}), 32'd0);
    chk("stray_ack_pc", 32'(pc_next_sel_o), 32'(P_STALL));
    @(negedge clk_i); mem_ack_i = 1'b0; #1;
    chk("stray_ack_after", 32'(busy_o), 32'd0);

    // SW with no ack: 16 wait cycles then timeout trap
    @(negedge clk_i); instr_i = I_SW; alu_result_i = 32'h200; instr_valid_i = 1'b1; #1;
    chk("sw_exec", 32'({mem_req_o, mem_wr_en_o}), 32'b11);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i); #1;
      chk("sw_wait", 32'({mem_req_o, mem_wr_en_o, busy_o, reg_wr_en_o, trap_o}), 32'b11100);
    end
    @(negedge clk_i); instr_valid_i = 1'b0; #1;
    chk("sw_trap", 32'(trap_o), 32'd1);
    chk("sw_trap_cause", 32'(trap_cause_o), 32'd1);
    chk("sw_trap_pc", 32'(pc_next_sel_o), 32'(P_TRAP));
    chk("sw_trap_quiet", 32'({mem_req_o, mem_wr_en_o, reg_wr_en_o, busy_o}), 32'd0);
    @(negedge clk_i); #1;
    chk("sw_trap_one_cycle", 32'(trap_o), 32'd0);

    // ack on the exact timeout cycle completes the load
    @(negedge clk_i); instr_i = I_LW; alu_result_i = 32'h104; instr_valid_i = 1'b1; #1;
    chk("lwto_exec", 32'(mem_req_o), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i); mem_ack_i = (k == 16); #1;
      chk("lwto_wr", 32'(reg_wr_en_o), 32'(k == 16));
    end
    chk("lwto_pc", 32'(pc_next_sel_o), 32'(P_NEXT));
    @(negedge clk_i); mem_ack_i = 1'b0; instr_valid_i = 1'b0; #1;
    chk("lwto_no_trap", 32'({trap_o, busy_o}), 32'd0);

    // illegal all-zero instruction
    @(negedge clk_i); instr_i = 32'h0; instr_valid_i = 1'b1; #1;
    chk("ill_exec", 32'({reg_wr_en_o, mem_req_o, mem_wr_en_o, trap_o}), 32'd0);
    @(negedge clk_i); instr_valid_i = 1'b0; #1;
    chk("ill_trap", 32'({trap_o, trap_cause_o}), 32'b100);
    chk("ill_trap_pc", 32'(pc_next_sel_o), 32'(P_TRAP));
    @(negedge clk_i); #1;
    chk("ill_one_cycle", 32'(trap_o), 32'd0);

    // LH at 0x102 is aligned
    @(negedge clk_i); instr_i = I_LH; alu_result_i = 32'h102; instr_valid_i = 1'b1; #1;
    chk("lh_req", 32'({mem_req_o, mem_acc_o}), 32'b101);
    @(negedge clk_i); mem_ack_i = 1'b1; #1;
    chk("lh_ack_wr", 32'(reg_wr_en_o), 32'd1);
    @(negedge clk_i); mem_ack_i = 1'b0; instr_valid_i = 1'b0; #1;

    // LW at 0x102 is misaligned
    @(negedge clk_i); instr_i = I_LW; alu_result_i = 32'h102; instr_valid_i = 1'b1; #1;
    chk("mis_no_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i); instr_valid_i = 1'b0; #1;
    chk("mis_trap", 32'({trap_o, trap_cause_o}), 32'b110);
    chk("mis_trap_no_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i); #1;

    // MUL
    @(negedge clk_i); instr_i = I_MUL; instr_valid_i = 1'b1; #1;
`ifdef CONTROL_SEQ_MULDIV_EN
    chk("mul_start", 32'(muldiv_start_o), 32'd1);
    chk("mul_exec", 32'({reg_wr_en_o, busy_o}), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i); #1;
      chk("mul_busy", 32'({busy_o, muldiv_start_o}), 32'b10);
      chk("mul_wr", 32'(reg_wr_en_o), 32'(k == 8));
      chk("mul_pc", 32'(pc_next_sel_o), (k == 8) ? 32'(P_NEXT) : 32'(P_STALL));
      if (k == 8) chk("mul_rd_sel", 32'(rd_sel_o), 32'd3);
    end
    @(negedge clk_i); instr_valid_i = 1'b0; #1;
    chk("mul_done", 32'(busy_o), 32'd0);
`else
    chk("mul_no_start", 32'({muldiv_start_o, reg_wr_en_o}), 32'd0);
    @(negedge clk_i); instr_valid_i = 1'b0; #1;
    chk("mul_trap", 32'({trap_o, trap_cause_o}), 32'b100);
    @(negedge clk_i); #1;
`endif

    // reset in the middle of MEM_WAIT
    @(negedge clk_i); instr_i = I_LW; alu_result_i = 32'h100; instr_valid_i = 1'b1; #1;
    @(negedge clk_i); #1;
    chk("mrst_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i); rst_i = 1'b1; #1;
    chk("mrst_zero", 32'(any_nz), 32'd0);
    chk("mrst_pc", 32'(pc_next_sel_o), 32'(P_STALL));
    @(negedge clk_i); rst_i = 1'b0; instr_i = I_ADDI; #1;
    chk("mrst_reset_state", 32'({reg_wr_en_o, mem_req_o}), 32'd0);
    @(negedge clk_i); #1;
    chk("mrst_exec_wr", 32'(reg_wr_en_o), 32'd1);
    chk("mrst_exec_pc", 32'(pc_next_sel_o), 32'(P_NEXT));
    @(negedge clk_i); instr_valid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
